// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx
// Receives the raw PS/2 keyboard clock/data pair and deserializes 11-bit
// device-to-host frames (start, 8 data bits LSB first, odd parity, stop).
// Scan-code set 2 prefixes (E0 extended, F0 release, E1 Pause) are folded
// into single key events on an 11-bit bus whose bit 10 toggles per event.
// The block only listens; it never drives the PS/2 lines.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   reset_n    asynchronous active-low reset
//   ps2_clk    raw PS/2 clock, asynchronous to clk
//   ps2_data   raw PS/2 data, asynchronous to clk
//   ps2_key    {toggle, press, extended, code[7:0]}
//   frame_err  one-cycle pulse on start/parity/stop error or timeout
module ps2_kbd_rx #(
   parameter int          FILTER_LEN = 8,
   parameter logic [15:0] TIMEOUT    = 16'd50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   localparam int          CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] FILT_MAX = CW'(FILTER_LEN - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

   logic          clkMeta_q, clkSync_q, dataMeta_q, dataSync_q;
   logic [CW-1:0] filtCnt_q, filtCnt_d;
   logic          filtClk_q, filtClk_d;
   logic          fallEdge;
   state_t        state_q, state_d;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [15:0]   toCnt_q, toCnt_d;
   logic          ext_q, ext_d, rel_q, rel_d;
   logic [2:0]    skip_q, skip_d;
   logic [10:0]   key_q, key_d;
   logic          err_d, err_q;
   logic          byteValid;

   // Synchronizers idle high so reset does not look like a falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clkMeta_q  <= 1'b1;
         clkSync_q  <= 1'b1;
         dataMeta_q <= 1'b1;
         dataSync_q <= 1'b1;
      end else begin
         clkMeta_q  <= ps2_clk;
         clkSync_q  <= clkMeta_q;
         dataMeta_q <= ps2_data;
         dataSync_q <= dataMeta_q;
      end
   end

   // Any sample that agrees with the filtered level restarts the run, so only
   // FILTER_LEN consecutive disagreeing samples move the filtered clock.
   always_comb begin
      filtCnt_d = filtCnt_q;
      filtClk_d = filtClk_q;
      if (clkSync_q == filtClk_q) begin
         filtCnt_d = '0;
      end else if (filtCnt_q == FILT_MAX) begin
         filtClk_d = clkSync_q;
         filtCnt_d = '0;
      end else begin
         filtCnt_d = filtCnt_q + 1'b1;
      end
   end

   assign fallEdge = filtClk_q & ~filtClk_d;

   // Frame FSM; the timeout check wins over any edge in the same cycle.
   always_comb begin
      state_d   = state_q;
      bitCnt_d  = bitCnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      err_d     = 1'b0;
      byteValid = 1'b0;
      if (state_q == IDLE || fallEdge) begin
         toCnt_d = '0;
      end else begin
         toCnt_d = toCnt_q + 16'd1;
      end
      if (state_q != IDLE && toCnt_q == TIMEOUT) begin
         err_d   = 1'b1;
         state_d = IDLE;
         toCnt_d = '0;
      end else if (fallEdge) begin
         case (state_q)
            IDLE: begin
               if (!dataSync_q) begin
                  state_d  = SHIFT;
                  bitCnt_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
            SHIFT: begin
               shift_d  = {dataSync_q, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               parity_d = dataSync_q;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dataSync_q && ((^shift_q) ^ parity_q)) begin
                  byteValid = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Prefix folding; after E1 the rest of the Pause sequence is swallowed.
   always_comb begin
      ext_d  = ext_q;
      rel_d  = rel_q;
      skip_d = skip_q;
      key_d  = key_q;
      if (byteValid) begin
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
               ext_d = 1'b0;
               rel_d = 1'b0;
            end
         end else begin
            case (shift_q)
               8'hE0: ext_d = 1'b1;
               8'hF0: rel_d = 1'b1;
               8'hE1: skip_d = 3'd7;
               8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
               end
               default: begin
                  key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                  ext_d = 1'b0;
                  rel_d = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filtCnt_q <= '0;
         filtClk_q <= 1'b1;
         state_q   <= IDLE;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         toCnt_q   <= '0;
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
         skip_q    <= '0;
         key_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         filtCnt_q <= filtCnt_d;
         filtClk_q <= filtClk_d;
         state_q   <= state_d;
         bitCnt_q  <= bitCnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         toCnt_q   <= toCnt_d;
         ext_q     <= ext_d;
         rel_q     <= rel_d;
         skip_q    <= skip_d;
         key_q     <= key_d;
         err_q     <= err_d;
      end
   end

   assign ps2_key   = key_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;

   localparam int          HALF    = 12;
   localparam logic [15:0] TO_LEN  = 16'd400;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_err;

   int checks = 0;
   int failures = 0;
   int eventCount = 0;
   int errPulses = 0;
   int errRun = 0;
   int maxErrWidth = 0;
   logic prevTog = 1'b0;
   int e0, p0;

   ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT(TO_LEN)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .ps2_key(ps2_key),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Watch the outputs on the falling clock edge: count toggle events,
   // frame_err pulses and the longest frame_err run.
   always @(negedge clk) begin
      if (ps2_key[10] !== prevTog) eventCount++;
      prevTog = ps2_key[10];
      if (frame_err) begin
         errRun++;
         if (errRun == 1) errPulses++;
         if (errRun > maxErrWidth) maxErrWidth = errRun;
      end else begin
         errRun = 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendBit(input logic b);
      ps2_data = b;
      waitCycles(HALF);
      ps2_clk = 1'b0;
      waitCycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic parFlip,
                                input logic stopBit);
      logic [10:0] frame;
      frame = {stopBit, (~^b) ^ parFlip, b, 1'b0};
      for (int i = 0; i < 11; i++) sendBit(frame[i]);
      ps2_data = 1'b1;
      waitCycles(3 * HALF);
   endtask

   initial begin
      logic [10:0] frame;
      #2 reset_n = 1'b0;
      waitCycles(4);
      checkOutput("reset_key", 32'(ps2_key), 32'h000);
      checkOutput("reset_err", 32'(frame_err), 32'h0);
      reset_n = 1'b1;
      waitCycles(5);

      // Make 'A' with exact latency after the stop-bit fall.
      frame = {1'b1, 1'b0, 8'h1C, 1'b0};
      for (int i = 0; i < 10; i++) sendBit(frame[i]);
      ps2_data = 1'b1;
      waitCycles(HALF);
      ps2_clk = 1'b0;
      waitCycles(9);
      checkOutput("makeA_before", 32'(ps2_key), 32'h000);
      waitCycles(1);
      checkOutput("makeA_after", 32'(ps2_key), 32'h61C);
      checkOutput("makeA_err", 32'(frame_err), 32'h0);
      waitCycles(HALF - 10);
      ps2_clk = 1'b1;
      waitCycles(3 * HALF);
      checkOutput("makeA_events", 32'(eventCount), 32'd1);
      checkOutput("makeA_errcnt", 32'(errPulses), 32'd0);

      // Extended release, then a plain make proves prefixes were cleared.
      e0 = eventCount;
      applyStimulus(8'hE0, 1'b0, 1'b1);
      applyStimulus(8'hF0, 1'b0, 1'b1);
      applyStimulus(8'h75, 1'b0, 1'b1);
      checkOutput("extrel_key", 32'(ps2_key), 32'h175);
      checkOutput("extrel_events", 32'(eventCount - e0), 32'd1);
      applyStimulus(8'h1C, 1'b0, 1'b1);
      checkOutput("flags_clear_key", 32'(ps2_key), 32'h61C);

      // Parity error, then a good frame.
      p0 = errPulses;
      applyStimulus(8'h1C, 1'b1, 1'b1);
      checkOutput("parity_errcnt", 32'(errPulses - p0), 32'd1);
      checkOutput("parity_key", 32'(ps2_key), 32'h61C);
      checkOutput("parity_width", 32'(maxErrWidth), 32'd1);
      applyStimulus(8'h1C, 1'b0, 1'b1);
      checkOutput("after_parity_key", 32'(ps2_key), 32'h21C);

      // Stop bit low.
      p0 = errPulses;
      applyStimulus(8'h1C, 1'b0, 1'b0);
      checkOutput("stop_errcnt", 32'(errPulses - p0), 32'd1);
      checkOutput("stop_key", 32'(ps2_key), 32'h21C);

      // Start bit high.
      p0 = errPulses;
      sendBit(1'b1);
      waitCycles(3 * HALF);
      checkOutput("start_errcnt", 32'(errPulses - p0), 32'd1);

      // Timeout after 5 clock pulses, then a full 0x29.
      p0 = errPulses;
      frame = {1'b1, ~^8'h29, 8'h29, 1'b0};
      for (int i = 0; i < 5; i++) sendBit(frame[i]);
      ps2_data = 1'b1;
      waitCycles(int'(TO_LEN) + 100);
      checkOutput("timeout_errcnt", 32'(errPulses - p0), 32'd1);
      checkOutput("timeout_key", 32'(ps2_key), 32'h21C);
      applyStimulus(8'h29, 1'b0, 1'b1);
      checkOutput("after_timeout_key", 32'(ps2_key), 32'h629);

      // Pause sequence swallowed, then 0x1C.
      e0 = eventCount;
      p0 = errPulses;
      applyStimulus(8'hE1, 1'b0, 1'b1);
      applyStimulus(8'h14, 1'b0, 1'b1);
      applyStimulus(8'h77, 1'b0, 1'b1);
      applyStimulus(8'hE1, 1'b0, 1'b1);
      applyStimulus(8'hF0, 1'b0, 1'b1);
      applyStimulus(8'h14, 1'b0, 1'b1);
      applyStimulus(8'hF0, 1'b0, 1'b1);
      applyStimulus(8'h77, 1'b0, 1'b1);
      applyStimulus(8'h1C, 1'b0, 1'b1);
      checkOutput("pause_events", 32'(eventCount - e0), 32'd1);
      checkOutput("pause_key", 32'(ps2_key), 32'h21C);
      checkOutput("pause_errcnt", 32'(errPulses - p0), 32'd0);

      // Short glitch on ps2_clk while idle.
      e0 = eventCount;
      p0 = errPulses;
      ps2_clk = 1'b0;
      waitCycles(3);
      ps2_clk = 1'b1;
      waitCycles(30);
      checkOutput("glitch_errcnt", 32'(errPulses - p0), 32'd0);
      checkOutput("glitch_events", 32'(eventCount - e0), 32'd0);

      // Reset after 4 bits of a frame.
      p0 = errPulses;
      frame = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
      for (int i = 0; i < 4; i++) sendBit(frame[i]);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_key", 32'(ps2_key), 32'h000);
      waitCycles(3);
      checkOutput("midreset_err", 32'(frame_err), 32'h0);
      ps2_data = 1'b1;
      reset_n = 1'b1;
      waitCycles(3 * HALF);
      checkOutput("midreset_errcnt", 32'(errPulses - p0), 32'd0);
      applyStimulus(8'h5A, 1'b0, 1'b1);
      checkOutput("after_reset_key", 32'(ps2_key), 32'h65A);

      // Typematic repeat gives one event per frame.
      e0 = eventCount;
      applyStimulus(8'h1C, 1'b0, 1'b1);
      applyStimulus(8'h1C, 1'b0, 1'b1);
      checkOutput("typematic_key", 32'(ps2_key), 32'h61C);
      checkOutput("typematic_events", 32'(eventCount - e0), 32'd2);
      checkOutput("err_width_final", 32'(maxErrWidth), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
